// File: rtl/vector_alu_sequencer_if.sv
// Dispatch-to-sequencer request bus and sequencer-to-lane issue bus.
// The master modport is the dispatch/lane side and the slave modport is the sequencer.
interface vector_alu_sequencer_if #(
  parameter int unsigned LANE_NUM = 4,
  parameter int unsigned MAX_ELEM = 32,
  parameter int unsigned IDX_W    = $clog2(MAX_ELEM) + 1
);
  logic                flush;
  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_vl;
  logic [2:0]          req_vsew;
  logic                req_vm;
  logic [5:0]          req_opcode;
  logic [MAX_ELEM-1:0] req_mask;
  logic                issue_valid;
  logic                issue_ready;
  logic [IDX_W-1:0]    issue_base_idx;
  logic [LANE_NUM-1:0] issue_lane_valid;
  logic [LANE_NUM-1:0] issue_lane_wen;
  logic [5:0]          issue_opcode;
  logic [2:0]          issue_vsew;
  logic                issue_last;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output flush, req_valid, req_vl, req_vsew, req_vm, req_opcode, req_mask, issue_ready,
    input  req_ready, issue_valid, issue_base_idx, issue_lane_valid, issue_lane_wen,
           issue_opcode, issue_vsew, issue_last, busy, done, err
  );

  modport slave (
    input  flush, req_valid, req_vl, req_vsew, req_vm, req_opcode, req_mask, issue_ready,
    output req_ready, issue_valid, issue_base_idx, issue_lane_valid, issue_lane_wen,
           issue_opcode, issue_vsew, issue_last, busy, done, err
  );
endinterface

// File: rtl/vector_alu_sequencer.sv
// Walks the elements of one vector ALU instruction in groups of LANE_NUM lanes,
// driving per-lane valid/write-enable for each group and pulsing done at the end.
module vector_alu_sequencer #(
  parameter int unsigned LANE_NUM = 4,
  parameter int unsigned VLEN     = 256,
  parameter int unsigned MAX_ELEM = VLEN / 8,
  parameter int unsigned IDX_W    = $clog2(MAX_ELEM) + 1
) (
  input logic                   clk,
  input logic                   rst_n,
  vector_alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone, StErr} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    vl_q;
  logic [MAX_ELEM-1:0] mask_q;
  logic                vm_q;
  logic [5:0]          opcode_q;
  logic [2:0]          vsew_q;
  logic [IDX_W-1:0]    base_q;
  logic [LANE_NUM-1:0] lane_valid_q;
  logic [LANE_NUM-1:0] lane_wen_q;
  logic                last_q;
  logic                issue_valid_q;
  logic                req_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  // vsew encodings 0..3 are 1/2/4/8-byte elements; anything with bit 2 set is illegal.
  logic             sew_legal;
  logic [IDX_W-1:0] elem_max;
  logic [IDX_W-1:0] req_vl_eff;

  assign sew_legal  = ~bus.req_vsew[2];
  assign elem_max   = IDX_W'(MAX_ELEM) >> bus.req_vsew[1:0];
  assign req_vl_eff = (bus.req_vl < elem_max) ? bus.req_vl : elem_max;

  // Next group's lane enables: first group comes from the live request, later ones from latches.
  logic [IDX_W-1:0]    src_vl;
  logic                src_vm;
  logic [MAX_ELEM-1:0] src_mask;
  logic [IDX_W-1:0]    nxt_base;
  logic [LANE_NUM-1:0] nxt_valid;
  logic [LANE_NUM-1:0] nxt_wen;
  logic                nxt_last;

  always_comb begin
    logic [IDX_W-1:0] elem;
    elem = '0;
    if (state_q == StIdle) begin
      src_vl   = req_vl_eff;
      src_vm   = bus.req_vm;
      src_mask = bus.req_mask;
      nxt_base = '0;
    end else begin
      src_vl   = vl_q;
      src_vm   = vm_q;
      src_mask = mask_q;
      nxt_base = base_q + IDX_W'(LANE_NUM);
    end
    nxt_valid = '0;
    nxt_wen   = '0;
    for (int unsigned k = 0; k < LANE_NUM; k++) begin
      elem         = nxt_base + IDX_W'(k);
      nxt_valid[k] = elem < src_vl;
      nxt_wen[k]   = nxt_valid[k] & (src_vm | src_mask[elem[IDX_W-2:0]]);
    end
    // One extra bit so base + LANE_NUM cannot wrap near MAX_ELEM.
    nxt_last = ({1'b0, nxt_base} + (IDX_W + 1)'(LANE_NUM)) >= {1'b0, src_vl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      vl_q          <= '0;
      mask_q        <= '0;
      vm_q          <= 1'b0;
      opcode_q      <= '0;
      vsew_q        <= '0;
      base_q        <= '0;
      lane_valid_q  <= '0;
      lane_wen_q    <= '0;
      last_q        <= 1'b0;
      issue_valid_q <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else if (bus.flush) begin
      state_q       <= StIdle;
      base_q        <= '0;
      lane_valid_q  <= '0;
      lane_wen_q    <= '0;
      last_q        <= 1'b0;
      issue_valid_q <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            opcode_q    <= bus.req_opcode;
            vsew_q      <= bus.req_vsew;
            vm_q        <= bus.req_vm;
            mask_q      <= bus.req_mask;
            vl_q        <= sew_legal ? req_vl_eff : '0;
            req_ready_q <= 1'b0;
            if (!sew_legal) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else if (req_vl_eff == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q       <= StIssue;
              busy_q        <= 1'b1;
              issue_valid_q <= 1'b1;
              base_q        <= nxt_base;
              lane_valid_q  <= nxt_valid;
              lane_wen_q    <= nxt_wen;
              last_q        <= nxt_last;
            end
          end
        end
        StIssue: begin
          if (bus.issue_ready) begin
            if (last_q) begin
              state_q       <= StDone;
              issue_valid_q <= 1'b0;
              done_q        <= 1'b1;
              base_q        <= '0;
              lane_valid_q  <= '0;
              lane_wen_q    <= '0;
              last_q        <= 1'b0;
            end else begin
              base_q       <= nxt_base;
              lane_valid_q <= nxt_valid;
              lane_wen_q   <= nxt_wen;
              last_q       <= nxt_last;
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        StErr: begin
          state_q     <= StIdle;
          err_q       <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.issue_valid      = issue_valid_q;
  assign bus.issue_base_idx   = base_q;
  assign bus.issue_lane_valid = lane_valid_q;
  assign bus.issue_lane_wen   = lane_wen_q;
  assign bus.issue_opcode     = opcode_q;
  assign bus.issue_vsew       = vsew_q;
  assign bus.issue_last       = last_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Bench for vector_alu_sequencer: directed table, flush/reset sequences and random requests
// checked against a group-list reference model.
module tb_vector_alu_sequencer;
  localparam int unsigned LANE_NUM = 4;
  localparam int unsigned VLEN     = 256;
  localparam int unsigned MAX_ELEM = VLEN / 8;
  localparam int unsigned IDX_W    = $clog2(MAX_ELEM) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_alu_sequencer_if #(.LANE_NUM(LANE_NUM), .MAX_ELEM(MAX_ELEM), .IDX_W(IDX_W)) bus ();

  vector_alu_sequencer #(.LANE_NUM(LANE_NUM), .VLEN(VLEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int vl_eff_of(input int vl, input int vsew);
    int em;
    em = MAX_ELEM >> vsew;
    return (vl < em) ? vl : em;
  endfunction

  // Called at a negedge with the sequencer idle; returns what it observed.
  task automatic run_req(input int vl, input int vsew, input bit vm,
                         input logic [MAX_ELEM-1:0] mask, input int opcode,
                         input int stall_pct, input int first_stall,
                         output int n_groups, output logic [LANE_NUM-1:0] first_wen,
                         output logic [LANE_NUM-1:0] last_valid,
                         output bit saw_done, output bit saw_err);
    int ve, exp_groups, g, cycles, stalls, e;
    logic [LANE_NUM-1:0] ev, ew;
    bit rdy;
    n_groups = 0; first_wen = '0; last_valid = '0; saw_done = 0; saw_err = 0;
    chk("ready_before_req", bus.req_ready, 1);
    bus.req_valid   = 1'b1;
    bus.req_vl      = IDX_W'(vl);
    bus.req_vsew    = 3'(vsew);
    bus.req_vm      = vm;
    bus.req_mask    = mask;
    bus.req_opcode  = 6'(opcode);
    bus.issue_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (vsew > 3) begin
      saw_err = bus.err;
      chk("err_pulse", bus.err, 1);
      chk("err_no_done", bus.done, 0);
      chk("err_no_issue", bus.issue_valid, 0);
      @(negedge clk);
      chk("err_one_cycle", bus.err, 0);
      chk("ready_after_err", bus.req_ready, 1);
      return;
    end
    ve = vl_eff_of(vl, vsew);
    exp_groups = (ve + LANE_NUM - 1) / LANE_NUM;
    if (ve == 0) begin
      saw_done = bus.done;
      chk("zero_vl_done", bus.done, 1);
      chk("zero_vl_no_issue", bus.issue_valid, 0);
      @(negedge clk);
      chk("zero_vl_done_one_cycle", bus.done, 0);
      chk("ready_after_zero_vl", bus.req_ready, 1);
      return;
    end
    g = 0; cycles = 0; stalls = 0;
    while (g < exp_groups) begin
      if (cycles > 400) begin
        total++; bad++;
        $display("FAIL issue_timeout actual=%0d groups required=%0d", g, exp_groups);
        break;
      end
      chk("issue_valid", bus.issue_valid, 1);
      if (bus.issue_valid !== 1'b1) break;
      ev = '0; ew = '0;
      for (int k = 0; k < LANE_NUM; k++) begin
        e = g * LANE_NUM + k;
        ev[k] = (e < ve);
        ew[k] = ev[k] && (vm || mask[e % MAX_ELEM]);
      end
      chk("base_idx", bus.issue_base_idx, g * LANE_NUM);
      chk("lane_valid", bus.issue_lane_valid, ev);
      chk("lane_wen", bus.issue_lane_wen, ew);
      chk("issue_last", bus.issue_last, (g == exp_groups - 1));
      chk("issue_opcode", bus.issue_opcode, opcode);
      chk("issue_vsew", bus.issue_vsew, vsew);
      chk("busy_in_issue", bus.busy, 1);
      chk("no_early_done", bus.done, 0);
      if (g == 0) first_wen = bus.issue_lane_wen;
      if (g == exp_groups - 1) last_valid = bus.issue_lane_valid;
      if (g == 0 && stalls < first_stall) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      bus.issue_ready = rdy;
      if (rdy) g++;
      @(negedge clk);
      cycles++;
    end
    n_groups = g;
    bus.issue_ready = 1'b0;
    saw_done = bus.done;
    chk("done_after_last", bus.done, 1);
    chk("no_issue_in_done", bus.issue_valid, 0);
    chk("busy_in_done", bus.busy, 1);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("ready_after_done", bus.req_ready, 1);
    chk("idle_not_busy", bus.busy, 0);
  endtask

  typedef struct {
    int                  vl;
    int                  vsew;
    bit                  vm;
    logic [MAX_ELEM-1:0] mask;
    int                  first_stall;
    int                  groups;
    logic [LANE_NUM-1:0] first_wen;
    logic [LANE_NUM-1:0] last_valid;
    bit                  exp_done;
    bit                  exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int ng;
    logic [LANE_NUM-1:0] fw, lv;
    bit sd, se;
    int vs, r;

    tbl[0] = '{10, 0, 1'b1, 32'h0,  0, 3, 4'b1111, 4'b0011, 1'b1, 1'b0};
    tbl[1] = '{8,  0, 1'b0, 32'h5A, 0, 2, 4'b1010, 4'b1111, 1'b1, 1'b0};
    tbl[2] = '{40, 3, 1'b1, 32'h0,  0, 1, 4'b1111, 4'b1111, 1'b1, 1'b0};
    tbl[3] = '{6,  0, 1'b1, 32'h0,  3, 2, 4'b1111, 4'b0011, 1'b1, 1'b0};
    tbl[4] = '{0,  0, 1'b1, 32'h0,  0, 0, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[5] = '{12, 7, 1'b1, 32'h0,  0, 0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[6] = '{32, 1, 1'b1, 32'h0,  0, 4, 4'b1111, 4'b1111, 1'b1, 1'b0};
    tbl[7] = '{32, 0, 1'b0, 32'h0,  0, 8, 4'b0000, 4'b1111, 1'b1, 1'b0};

    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_vl = '0; bus.req_vsew = '0;
    bus.req_vm = 1'b0; bus.req_opcode = '0; bus.req_mask = '0; bus.issue_ready = 1'b0;

    #12;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_issue_valid", bus.issue_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_last", bus.issue_last, 0);
    chk("rst_lane_valid", bus.issue_lane_valid, 0);
    chk("rst_lane_wen", bus.issue_lane_wen, 0);
    chk("rst_base", bus.issue_base_idx, 0);
    chk("rst_opcode", bus.issue_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].vl, tbl[i].vsew, tbl[i].vm, tbl[i].mask, 6'h11 + i, 0, tbl[i].first_stall,
              ng, fw, lv, sd, se);
      chk("tbl_groups", ng, tbl[i].groups);
      chk("tbl_first_wen", fw, tbl[i].first_wen);
      chk("tbl_last_valid", lv, tbl[i].last_valid);
      chk("tbl_done", sd, tbl[i].exp_done);
      chk("tbl_err", se, tbl[i].exp_err);
    end

    // Flush during the second group, with issue_ready high to show flush wins.
    bus.req_valid = 1'b1; bus.req_vl = IDX_W'(16); bus.req_vsew = 3'd0; bus.req_vm = 1'b1;
    bus.req_mask = '0; bus.req_opcode = 6'h2A; bus.issue_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("flush_g0_base", bus.issue_base_idx, 0);
    @(negedge clk);
    chk("flush_g1_valid", bus.issue_valid, 1);
    chk("flush_g1_base", bus.issue_base_idx, 4);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.issue_ready = 1'b0;
    chk("flush_issue_valid", bus.issue_valid, 0);
    chk("flush_no_done", bus.done, 0);
    chk("flush_req_ready", bus.req_ready, 1);
    chk("flush_busy", bus.busy, 0);
    @(negedge clk);
    chk("flush_no_late_done", bus.done, 0);
    run_req(5, 0, 1'b1, '0, 6'h05, 0, 0, ng, fw, lv, sd, se);
    chk("post_flush_groups", ng, 2);
    chk("post_flush_last_valid", lv, 4'b0001);

    // Asynchronous reset in the middle of an instruction.
    bus.req_valid = 1'b1; bus.req_vl = IDX_W'(16); bus.req_vsew = 3'd0; bus.req_vm = 1'b1;
    bus.req_opcode = 6'h3C; bus.issue_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_issue_valid", bus.issue_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_lane_valid", bus.issue_lane_valid, 0);
    chk("arst_base", bus.issue_base_idx, 0);
    chk("arst_req_ready", bus.req_ready, 1);
    chk("arst_opcode", bus.issue_opcode, 0);
    bus.issue_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_done", bus.done, 0);
    chk("arst_no_err", bus.err, 0);
    run_req(9, 1, 1'b0, 32'hFFFF_0F0F, 6'h01, 0, 0, ng, fw, lv, sd, se);
    chk("post_arst_groups", ng, 3);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(9);
      vs = (r < 8) ? (r % 4) : 4 + $urandom_range(3);
      run_req($urandom_range(40), vs, 1'($urandom_range(1)), MAX_ELEM'($urandom),
              $urandom_range(63), 30, 0, ng, fw, lv, sd, se);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
